multi_trigger_gen: RTL and testbench
====================================

# multi_trigger_gen

Parametrised multi-channel periodic/one-shot trigger generator. Each of CH independent channels counts a programmable period and emits a registered trigger pulse of programmable width. Channels can be started, stopped and reconfigured at run time. The block sits beside the control logic as the shared timebase source for strobes that were previously produced by single fixed-period dividers.

## Interface
- CH, 4, number of channels (1..16)
- CNT_W, 8, width of period/width counters
- DEF_PERIOD, 2, period loaded into every channel at reset (1..2^CNT_W-1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(CH) (min 1)  channel addressed by cfg_we
- cfg_period  in  CNT_W  period in cycles; 0 treated as 1
- cfg_width  in  CNT_W  pulse width in cycles; 0 treated as 1, clamped to period
- cfg_oneshot  in  1  0 = periodic, 1 = one-shot
- start  in  CH  per-channel start/restart request (level sampled each edge)
- stop  in  CH  per-channel stop request
- trigger  out  CH  registered trigger pulses
- busy  out  CH  channel in RUN state

## Operation
- Per channel: shadow config (PER, WID, OS) and active config; cnt (CNT_W), pulse counter pw (CNT_W).
- cfg_we writes shadow of channel cfg_ch; cfg_ch >= CH ignored.
- Shadow copied to active: on accepted start, and at every period wrap while running.
- States: IDLE, RUN.
  - IDLE -> RUN: start[i]=1 and stop[i]=0; cnt <= 0.
  - RUN: cnt increments; when cnt == PER-1 (finished), cnt <= 0 and pw <= WID.
  - RUN -> IDLE: stop[i]=1 (cnt <= 0, pw <= 0, trigger low next cycle); or OS=1 and finished (pulse still completes its width).
  - RUN + start: restart, cnt <= 0, pending pulse cancelled (pw <= 0).
- trigger[i] registered: high in cycle after finished, and for WID cycles total.
- PER=1, WID=1, periodic: trigger constantly high from 2nd cycle after start.
- Simultaneous start & stop on a channel: stop wins.
- cfg_we and start same cycle, same channel: start uses newly written values.
- Counter arithmetic is CNT_W-bit unsigned; cnt never exceeds PER-1.

## Timing
- Reset (rst=0 at an edge): all channels IDLE, cnt=0, pw=0, trigger=0, busy=0, shadow/active PER=DEF_PERIOD, WID=1, OS=0. Reset mid-pulse truncates the pulse next edge.
- start sampled at edge E: busy=1 after E; first trigger rises after edge E+PER, lasts min(WID,PER) cycles.
- Periodic: rising edges of trigger exactly PER cycles apart.
- Stop sampled at edge E: busy=0 and trigger=0 after E.
- One-shot: busy falls at the same edge trigger rises.
- Config write while running: takes effect from the next period (no mid-period change).

## Configuration
- Macro TRIG_COUNT_EN.
- Defined: extra output trig_cnt, CH*16 bits; per channel, count of trigger rising edges since last accepted start, saturating at 16'hFFFF, cleared on reset and on accepted start.
- Not defined: port and counters absent; other behaviour identical.

## Structure
- Package trig_pkg: state enum (IDLE, RUN), channel config struct (period, width, oneshot), constant TRIG_CNT_W=16 for the event counter.
- Sub-module trig_chan: one channel (state, counters, shadow/active config, trigger register); top generates CH instances and decodes cfg_ch.

## Test plan
- Reset, then start[0] with DEF_PERIOD=2, WID=1 -> trigger[0] high every 2nd cycle, first rise 2 cycles after start edge; others stay 0.
- Write ch1 PER=5, WID=3, periodic; start -> trigger[1] high 3 cycles, low 2, repeating; rises 5 cycles apart.
- Write ch2 PER=4, WID=2, one-shot; start -> single 2-cycle pulse 4 cycles after start; busy[2] falls at pulse rise.
- Ch1 running PER=5; write PER=3 mid-period -> current period completes at 5, next rises at 3-cycle spacing; WID=9 with PER=3 -> clamped to 3 (constant high).
- start and stop asserted together on ch0 while running -> channel idles, trigger[0]=0 next cycle; rst=0 mid-pulse -> all outputs 0 next cycle.
- With TRIG_COUNT_EN: 10 periods on ch3 -> trig_cnt[3]=10; restart -> 0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared types and helpers for the multi-channel trigger generator.
// Used by trig_chan and multi_trigger_gen (optional TRIG_COUNT_EN event counters).
package trig_pkg;

    // Channel run state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Width of the per-channel trigger event counter.
    localparam int TRIG_CNT_W = 16;

    // Storage width of period/width fields. This is the widest counter width
    // the channel supports. Narrower CNT_W values are zero-extended into it.
    localparam int CFG_W = 16;

    // One channel's configuration as it is held in the shadow and active copies.
    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] width;
        logic             oneshot;
    } chan_cfg_t;

    // Normalise a raw configuration write.
    // A zero period or width behaves as one. The width never exceeds the period.
    function automatic chan_cfg_t norm_cfg(input logic [CFG_W-1:0] period,
                                           input logic [CFG_W-1:0] width,
                                           input logic             oneshot);
        chan_cfg_t c;
        c.period  = (period == '0) ? CFG_W'(1) : period;
        c.width   = (width == '0) ? CFG_W'(1) : width;
        if (c.width > c.period) begin
            c.width = c.period;
        end
        c.oneshot = oneshot;
        return c;
    endfunction

    // Configuration every channel wakes up with: the default period,
    // a one-cycle pulse, and periodic mode.
    function automatic chan_cfg_t reset_cfg(input int def_period);
        chan_cfg_t c;
        c.period  = CFG_W'(def_period);
        c.width   = CFG_W'(1);
        c.oneshot = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/trig_chan.sv
// One trigger channel.
// It holds the period counter, the pulse-width counter, the shadow and active
// configuration, and the registered trigger output.
// Optional macro TRIG_COUNT_EN adds a saturating count of trigger rising edges.
module trig_chan
    import trig_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             trigger,
    output logic             busy
`ifdef TRIG_COUNT_EN
    ,
    output logic [TRIG_CNT_W-1:0] trig_cnt
`endif
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic             trig_q, trig_d;
    chan_cfg_t        shadow_q, shadow_d;
    chan_cfg_t        active_q, active_d;
    logic             start_acc;
    logic             finished;

    // Stop beats start when both arrive in the same cycle.
    assign start_acc = start & ~stop;

    // The last cycle of the current period. The counter restarts on the next edge.
    assign finished  = (state_q == RUN) &&
                       (CFG_W'(cnt_q) == (active_q.period - CFG_W'(1)));

    // Next-state logic: the FSM, both counters, the config copies, and the trigger.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        shadow_d = cfg_we ? norm_cfg(CFG_W'(cfg_period), CFG_W'(cfg_width), cfg_oneshot)
                          : shadow_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        pw_d     = (pw_q != '0) ? pw_q - CNT_W'(1) : '0;
        active_d = active_q;

        case (state_q)
            IDLE: begin
                // A one-shot tail still in flight is left to finish.
                if (start_acc) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    active_d = shadow_d;
                end
            end
            RUN: begin
                if (start_acc) begin
                    // Restart: begin a fresh period and drop any pulse in progress.
                    cnt_d    = '0;
                    pw_d     = '0;
                    active_d = shadow_d;
                end else if (finished) begin
                    cnt_d    = '0;
                    pw_d     = CNT_W'(active_q.width);
                    active_d = shadow_d;
                    if (active_q.oneshot) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A stop idles the channel and silences the trigger on the same edge.
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            pw_d    = '0;
        end

        trig_d = (pw_d != '0);
    end

    // State register, with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments,
        // so every flop samples values from before the edge.
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pw_q     <= '0;
            trig_q   <= 1'b0;
            // NOTE: the config registers are reset on purpose.
            // After reset, a start must run with the default period.
            shadow_q <= reset_cfg(DEF_PERIOD);
            active_q <= reset_cfg(DEF_PERIOD);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pw_q     <= pw_d;
            trig_q   <= trig_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign trigger = trig_q;
    assign busy    = (state_q == RUN);

`ifdef TRIG_COUNT_EN
    logic [TRIG_CNT_W-1:0] ev_cnt_q;

    // Count trigger rising edges since the last accepted start, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_cnt_q <= '0;
        end else if (start_acc) begin
            ev_cnt_q <= '0;
        end else if (trig_d && !trig_q && (ev_cnt_q != '1)) begin
            ev_cnt_q <= ev_cnt_q + TRIG_CNT_W'(1);
        end
    end

    assign trig_cnt = ev_cnt_q;
`endif

endmodule

// File: rtl/multi_trigger_gen.sv
// Multi-channel periodic / one-shot trigger generator.
// The top level builds CH trig_chan instances and decodes the config write
// address so it reaches a single channel.
// Optional macro TRIG_COUNT_EN exposes trig_cnt: a 16-bit rising-edge count
// for each channel.
module multi_trigger_gen
    import trig_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                    cfg_period,
    input  logic [CNT_W-1:0]                    cfg_width,
    input  logic                                cfg_oneshot,
    input  logic [CH-1:0]                       start,
    input  logic [CH-1:0]                       stop,
    output logic [CH-1:0]                       trigger,
    output logic [CH-1:0]                       busy
`ifdef TRIG_COUNT_EN
    ,
    output logic [CH*TRIG_CNT_W-1:0]            trig_cnt
`endif
);

    localparam int CH_AW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0] ch_we;

    // Write-enable decode. An address at or above CH matches no channel,
    // so that write is dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CH; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_AW'(i));
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        trig_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cfg_we      (ch_we[g]),
            .cfg_period  (cfg_period),
            .cfg_width   (cfg_width),
            .cfg_oneshot (cfg_oneshot),
            .start       (start[g]),
            .stop        (stop[g]),
            .trigger     (trigger[g]),
            .busy        (busy[g])
`ifdef TRIG_COUNT_EN
            ,
            .trig_cnt    (trig_cnt[g*TRIG_CNT_W +: TRIG_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_multi_trigger_gen.sv
// Testbench for multi_trigger_gen (CH=4, CNT_W=8, DEF_PERIOD=2).
// It runs three kinds of stimulus:
//   - table-driven vectors,
//   - hand-written multi-cycle sequences,
//   - randomized traffic checked against a timestamp-based reference model.
// Define TRIG_COUNT_EN to also exercise trig_cnt.
module tb_multi_trigger_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_period;
    logic [7:0]  cfg_width;
    logic        cfg_oneshot;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  trigger;
    logic [3:0]  busy;
`ifdef TRIG_COUNT_EN
    logic [63:0] trig_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_trigger_gen #(
        .CH         (4),
        .CNT_W      (8),
        .DEF_PERIOD (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_width   (cfg_width),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .trigger     (trigger),
        .busy        (busy)
`ifdef TRIG_COUNT_EN
        ,
        .trig_cnt    (trig_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: absolute time stamps per channel.
    // A channel fires at time next_fire. Its trigger is high while the
    // current edge index is below pulse_until.
    // ------------------------------------------------------------------
    longint      m_t;
    int unsigned m_sh_per [4];
    int unsigned m_sh_wid [4];
    bit          m_sh_os  [4];
    int unsigned m_ac_per [4];
    int unsigned m_ac_wid [4];
    bit          m_ac_os  [4];
    bit          m_run    [4];
    longint      m_next   [4];
    longint      m_until  [4];
    int unsigned m_cnt    [4];
    bit          m_prev   [4];

    task automatic model_step();
        int unsigned np;
        int unsigned nw;
        m_t++;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_sh_per[i] = 2; m_sh_wid[i] = 1; m_sh_os[i] = 0;
                m_ac_per[i] = 2; m_ac_wid[i] = 1; m_ac_os[i] = 0;
                m_run[i] = 0; m_next[i] = 0; m_until[i] = 0;
                m_cnt[i] = 0; m_prev[i] = 0;
            end
            return;
        end
        np = (cfg_period == 0) ? 1 : cfg_period;
        nw = (cfg_width == 0) ? 1 : cfg_width;
        if (nw > np) nw = np;
        for (int i = 0; i < 4; i++) begin
            int unsigned sp;
            int unsigned sw;
            bit          so;
            bit          old_os;
            bit          tr;
            sp = m_sh_per[i]; sw = m_sh_wid[i]; so = m_sh_os[i];
            if (cfg_we && (int'(cfg_ch) == i)) begin
                sp = np; sw = nw; so = cfg_oneshot;
            end
            if (stop[i]) begin
                m_run[i]   = 0;
                m_until[i] = m_t;
            end else if (start[i]) begin
                if (m_run[i]) m_until[i] = m_t;
                m_run[i]    = 1;
                m_ac_per[i] = sp; m_ac_wid[i] = sw; m_ac_os[i] = so;
                m_next[i]   = m_t + m_ac_per[i];
            end else if (m_run[i] && (m_t == m_next[i])) begin
                m_until[i]  = m_t + m_ac_wid[i];
                old_os      = m_ac_os[i];
                m_ac_per[i] = sp; m_ac_wid[i] = sw; m_ac_os[i] = so;
                if (old_os) m_run[i] = 0;
                else        m_next[i] = m_t + m_ac_per[i];
            end
            m_sh_per[i] = sp; m_sh_wid[i] = sw; m_sh_os[i] = so;
            tr = (m_t < m_until[i]);
            if (start[i] && !stop[i]) m_cnt[i] = 0;
            else if (tr && !m_prev[i] && (m_cnt[i] < 65535)) m_cnt[i]++;
            m_prev[i] = tr;
        end
    endtask

    function automatic logic [3:0] model_trig();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_t < m_until[i]);
        return v;
    endfunction

    function automatic logic [3:0] model_busy();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_run[i];
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge. Outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
        cfg_oneshot = 1'b0; start = '0; stop = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic write_cfg(input int ch, input int per, input int wid, input bit os);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(per);
        cfg_width = 8'(wid); cfg_oneshot = os;
    endtask

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] ch;
        logic [7:0] per;
        logic [7:0] wid;
        logic       os;
        logic [3:0] start;
        logic [3:0] stop;
        logic [3:0] exp_trig;
        logic [3:0] exp_busy;
    } vec_t;

    vec_t vt [20];

    initial begin
        rst = 1'b0;
        quiet_inputs();
        m_t = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh_per[i] = 2; m_sh_wid[i] = 1; m_sh_os[i] = 0;
            m_ac_per[i] = 2; m_ac_wid[i] = 1; m_ac_os[i] = 0;
            m_run[i] = 0; m_next[i] = 0; m_until[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
        end

        // ---- Table: reset, default-period ch0, one-shot ch2, zero cfg ch3 ----
        //           rst we ch    per wid os start    stop     trig     busy
        vt[0]  = '{0, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[2]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vt[3]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vt[4]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        vt[5]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vt[6]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        vt[7]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vt[8]  = '{1, 1, 2'd2, 4, 2, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vt[9]  = '{1, 0, 2'd0, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        vt[10] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vt[11] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vt[12] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vt[13] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        vt[14] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        vt[15] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[16] = '{1, 1, 2'd3, 0, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        vt[17] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        vt[18] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        vt[19] = '{1, 0, 2'd0, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000};

        for (int r = 0; r < 20; r++) begin
            rst = vt[r].rst; cfg_we = vt[r].we; cfg_ch = vt[r].ch;
            cfg_period = vt[r].per; cfg_width = vt[r].wid; cfg_oneshot = vt[r].os;
            start = vt[r].start; stop = vt[r].stop;
            tick();
            check($sformatf("table[%0d] trigger", r), 32'(trigger), 32'(vt[r].exp_trig));
            check($sformatf("table[%0d] busy", r), 32'(busy), 32'(vt[r].exp_busy));
        end
        quiet_inputs();

        // ---- ch1 PER=5 WID=3 periodic, then PER=3 WID=9 written mid-period ----
        do_reset();
        write_cfg(1, 5, 3, 0);
        tick();
        quiet_inputs();
        start = 4'b0010;
        tick();
        start = 4'b0000;
        check("ch1 start busy", 32'(busy), 32'h2);
        for (int k = 1; k <= 25; k++) begin
            logic exp_t;
            if (k == 12) write_cfg(1, 3, 9, 0);
            tick();
            quiet_inputs();
            if (k < 5)       exp_t = 1'b0;
            else if (k < 15) exp_t = ((k - 5) % 5) < 3;
            else             exp_t = 1'b1;
            check($sformatf("ch1 k=%0d trigger", k), 32'(trigger), {28'h0, 1'b0, 1'b0, exp_t, 1'b0});
        end
        start = 4'b0010; stop = 4'b0010;
        tick();
        quiet_inputs();
        check("start+stop trigger", 32'(trigger), 32'h0);
        check("start+stop busy", 32'(busy), 32'h0);

        // ---- reset mid-pulse, then the default period is back on ch1 ----
        do_reset();
        start = 4'b0011;
        tick();
        start = 4'b0000;
        tick();
        check("pre-reset k=1 trigger", 32'(trigger), 32'h0);
        tick();
        check("pre-reset k=2 trigger", 32'(trigger), 32'h3);
        rst = 1'b0;
        tick();
        check("mid-pulse reset trigger", 32'(trigger), 32'h0);
        check("mid-pulse reset busy", 32'(busy), 32'h0);
        rst = 1'b1;
        start = 4'b0010;
        tick();
        start = 4'b0000;
        check("post-reset start busy", 32'(busy), 32'h2);
        tick();
        check("post-reset k=1 trigger", 32'(trigger), 32'h0);
        tick();
        check("post-reset k=2 trigger", 32'(trigger), 32'h2);

`ifdef TRIG_COUNT_EN
        // ---- event counter: 10 periods on ch3, then restart clears ----
        do_reset();
        write_cfg(3, 3, 1, 0);
        tick();
        quiet_inputs();
        start = 4'b1000;
        tick();
        start = 4'b0000;
        check("trig_cnt after start", 32'(trig_cnt[63:48]), 32'd0);
        for (int k = 1; k <= 30; k++) tick();
        check("trig_cnt 10 periods", 32'(trig_cnt[63:48]), 32'd10);
        start = 4'b1000;
        tick();
        start = 4'b0000;
        check("trig_cnt restart", 32'(trig_cnt[63:48]), 32'd0);
`endif

        // ---- randomized traffic against the reference model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 399) != 0);
            cfg_we      = ($urandom_range(0, 4) == 0);
            cfg_ch      = 2'($urandom_range(0, 3));
            cfg_period  = 8'($urandom_range(0, 7));
            cfg_width   = 8'($urandom_range(0, 8));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                start[i] = ($urandom_range(0, 19) == 0);
                stop[i]  = ($urandom_range(0, 29) == 0);
            end
            tick();
            check($sformatf("rand[%0d] trigger", n), 32'(trigger), 32'(model_trig()));
            check($sformatf("rand[%0d] busy", n), 32'(busy), 32'(model_busy()));
`ifdef TRIG_COUNT_EN
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rand[%0d] trig_cnt%0d", n, i),
                      32'(trig_cnt[i*16 +: 16]), m_cnt[i]);
            end
`endif
        end
        quiet_inputs();
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
